pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Parametrised stall/flush/valid controller for the in-order LC-3b pipeline; it replaces the free-running per-stage load and valid wiring of the current datapath.
- Generates per-stage pipe-register load enables, PC load and branch redirect.
- Tracks per-stage valid bits, inserting bubbles on I-cache miss, D-cache wait and decode hazard, and squashing wrong-path instructions on a taken branch.
- Maintains saturating stall and flush performance counters.

Parameters:
STAGES, 5, number of pipeline stages; stage 0 = fetch, stage STAGES-1 = writeback; legal range >= 4
MEM_STAGE, 3, index of the stage that accesses D-memory and resolves branches; legal range 2..STAGES-2
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_mem_resp  in  1  I-memory returned fetch data this cycle
d_mem_req  in  1  instruction in MEM_STAGE performs a read or write
d_mem_resp  in  1  D-memory access complete this cycle
load_hazard  in  1  decode (stage 1) must stall, e.g. load-use
br_taken  in  1  branch in MEM_STAGE is taken (cccomp AND br_op)
cnt_clear  in  1  zero both counters
load_pc  out  1  PC register load enable
redirect  out  1  pcmux selects branch target
load_reg  out  STAGES-1  bit k: load enable of pipe register between stage k and stage k+1
stage_valid  out  STAGES  bit k: stage k holds a valid instruction; bit 0 = ~reset
stall_count  out  CNT_WIDTH  cycles with any freeze
flush_count  out  CNT_WIDTH  taken-branch flushes

Behaviour:
- State: valid bits v[STAGES-1:1], stall_count, flush_count.
- Reset: all of state cleared to 0. While reset is high, load_pc=0, redirect=0, load_reg=0, stage_valid=0.
- dstall = v[MEM_STAGE] & d_mem_req & ~d_mem_resp.
- Freeze point f is combinational, with priority in this order:
  - dstall -> f=MEM_STAGE
  - else v[1] & load_hazard -> f=1
  - else ~i_mem_resp -> f=0
  - else f=none
- br_take = br_taken & v[MEM_STAGE] & ~dstall. It is ignored while the branch stage is invalid or stalled; the redirect happens on the cycle the D-stall releases.
- Outputs (all combinational, same cycle):
  - load_pc = (f==none) | br_take
  - redirect = br_take
  - load_reg[k] = 1 iff f==none or k >= f. Registers before the freeze point hold; register f captures a bubble.
- Valid update at each edge, for k=1..STAGES-1, with v_in(0) = 1:
  - k-1 > f or f==none: v[k] <= v_in(k-1)
  - k-1 == f: v[k] <= 0 (bubble)
  - k-1 < f: v[k] holds
- Flush overrides the valid update: on br_take, v[1..MEM_STAGE] <= 0 and v[MEM_STAGE+1] <= 1 (the branch advances).
- Writeback (stage STAGES-1) never stalls. Its valid bit simply follows the rule above.
- Counters:
  - stall_count += 1 each cycle with f != none.
  - flush_count += 1 on br_take.
  - Both saturate at all-ones.
  - cnt_clear has priority over increment; reset clears both.
- Simultaneous events:
  - dstall with hazard or I-miss: dstall wins, and one stall cycle is counted.
  - Hazard with br_take: the flush squashes the stalled decode instruction and the PC loads the target.
- Reset asserted mid-stall or mid-flush: next edge gives all v=0 and counters 0, with no residual redirect.
- Latency:
  - A fetched instruction reaches stage k after k edges without stalls.
  - Branch redirect takes effect at the same edge the branch leaves MEM_STAGE.

Test Plan:
1. Defaults, release reset, i_mem_resp=1, no stalls -> stage_valid 00001, 00011, 00111, 01111, 11111 on successive cycles; load_reg=1111 and load_pc=1 throughout.
2. v[3]=1, d_mem_req=1, d_mem_resp=0 for 3 cycles -> load_pc=0 and load_reg=1000 for 3 cycles; v[4]=0 after first edge; v[3:1] held; stall_count=3; resp=1 -> full advance.
3. load_hazard=1 for 1 cycle with v[1]=1 -> load_pc=0, load_reg=1110; next v[2]=0 and v[1] held; i_mem_resp=0 alone -> load_reg=1111, next v[1]=0.
4. Full pipe, br_taken=1 -> redirect=1, load_pc=1; next stage_valid[3:1]=000, v[4]=1; flush_count=1.
5. br_taken=1 with dstall for 2 cycles -> redirect=0 for both cycles; on d_mem_resp=1, redirect=1 and flush applied once.
6. CNT_WIDTH=4: 20 consecutive I-miss cycles -> stall_count=15; cnt_clear=1 -> 0 next cycle; reset during stall -> stage_valid=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/valid controller for the in-order LC-3b pipeline.
// Produces the per-stage pipe-register load enables, the PC load and the
// branch redirect, tracks which stages hold real instructions, and keeps
// saturating counters of freeze cycles and taken-branch flushes.
module pipeline_ctrl #(
    parameter int STAGES    = 5,
    parameter int MEM_STAGE = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_mem_resp,
    input  logic                 d_mem_req,
    input  logic                 d_mem_resp,
    input  logic                 load_hazard,
    input  logic                 br_taken,
    input  logic                 cnt_clear,
    output logic                 load_pc,
    output logic                 redirect,
    output logic [STAGES-2:0]    load_reg,
    output logic [STAGES-1:0]    stage_valid,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int FW = $clog2(STAGES);

    // Valid bits of stages 1..STAGES-1; fetch (stage 0) is always valid
    // outside reset, so it has no storage.
    logic [STAGES-1:1] v;
    logic [STAGES-1:1] v_next;
    logic [STAGES-1:0] v_in;

    logic          dstall;
    logic          freeze;
    logic [FW-1:0] freeze_pt;
    logic          br_take;

    // Pick the single freeze point; the deepest stalled stage wins so that
    // a D-cache wait swallows any hazard or I-miss behind it.
    always_comb begin
        dstall    = v[MEM_STAGE] & d_mem_req & ~d_mem_resp;
        freeze    = 1'b1;
        freeze_pt = '0;
        if (dstall) begin
            freeze_pt = FW'(MEM_STAGE);
        end else if (v[1] & load_hazard) begin
            freeze_pt = FW'(1);
        end else if (!i_mem_resp) begin
            freeze_pt = '0;
        end else begin
            freeze = 1'b0;
        end
        br_take = br_taken & v[MEM_STAGE] & ~dstall;
    end

    // Control outputs: registers at or past the freeze point keep moving
    // (the one at the freeze point captures a bubble); all silenced in reset.
    always_comb begin
        load_reg = '0;
        for (int k = 0; k < STAGES - 1; k++) begin
            load_reg[k] = ~freeze | (k >= int'(freeze_pt));
        end
        load_pc     = ~freeze | br_take;
        redirect    = br_take;
        stage_valid = {v, 1'b1};
        if (reset) begin
            load_reg    = '0;
            load_pc     = 1'b0;
            redirect    = 1'b0;
            stage_valid = '0;
        end
    end

    // Next valid vector: shift past the freeze point, bubble into the stage
    // right after it, hold before it; a taken branch squashes the wrong path
    // younger than itself while the branch itself moves on.
    always_comb begin
        v_in   = {v, 1'b1};
        v_next = v;
        for (int k = 1; k < STAGES; k++) begin
            if (!freeze || (k - 1 > int'(freeze_pt))) begin
                v_next[k] = v_in[k-1];
            end else if (k - 1 == int'(freeze_pt)) begin
                v_next[k] = 1'b0;
            end else begin
                v_next[k] = v[k];
            end
        end
        if (br_take) begin
            for (int k = 1; k <= MEM_STAGE; k++) begin
                v_next[k] = 1'b0;
            end
            v_next[MEM_STAGE+1] = 1'b1;
        end
    end

    // State update: valid bits plus saturating counters, clear beats count.
    always_ff @(posedge clk) begin
        if (reset) begin
            v           <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            v <= v_next;
            if (cnt_clear) begin
                stall_count <= '0;
                flush_count <= '0;
            end else begin
                if (freeze && (stall_count != {CNT_WIDTH{1'b1}})) begin
                    stall_count <= stall_count + 1'b1;
                end
                if (br_take && (flush_count != {CNT_WIDTH{1'b1}})) begin
                    flush_count <= flush_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios for pipeline_ctrl with 5 stages,
// branch resolution in stage 3 and 4-bit counters so saturation is reachable.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_mem_resp;
    logic       d_mem_req;
    logic       d_mem_resp;
    logic       load_hazard;
    logic       br_taken;
    logic       cnt_clear;
    logic       load_pc;
    logic       redirect;
    logic [3:0] load_reg;
    logic [4:0] stage_valid;
    logic [3:0] stall_count;
    logic [3:0] flush_count;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl #(
        .STAGES    (5),
        .MEM_STAGE (3),
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_mem_resp  (i_mem_resp),
        .d_mem_req   (d_mem_req),
        .d_mem_resp  (d_mem_resp),
        .load_hazard (load_hazard),
        .br_taken    (br_taken),
        .cnt_clear   (cnt_clear),
        .load_pc     (load_pc),
        .redirect    (redirect),
        .load_reg    (load_reg),
        .stage_valid (stage_valid),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_mem_resp  = 1'b1;
        d_mem_req   = 1'b0;
        d_mem_resp  = 1'b0;
        load_hazard = 1'b0;
        br_taken    = 1'b0;
        cnt_clear   = 1'b0;
    endtask

    // Four clean edges always fill a 5-stage pipe completely.
    task automatic refill(input string tag);
        idle_inputs();
        repeat (4) tick();
        n_cmp++;
        if (stage_valid !== 5'b11111) begin
            n_err++;
            $display("[TB] FAIL %s_refill: stage_valid got %b want 11111", tag, stage_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if ({stage_valid, load_reg, load_pc, redirect} !== 11'b0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: sv=%b lr=%b pc=%b rd=%b want all 0",
                     stage_valid, load_reg, load_pc, redirect);
        end
        n_cmp++;
        if ({stall_count, flush_count} !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_counts: stall=%0d flush=%0d want 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_fill();
        logic [4:0] exp_sv;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp_sv = 5'((1 << (i + 1)) - 1);
            n_cmp++;
            if (stage_valid !== exp_sv || load_reg !== 4'b1111 || load_pc !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL fill_%0d: sv=%b lr=%b pc=%b want sv=%b lr=1111 pc=1",
                         i, stage_valid, load_reg, load_pc, exp_sv);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_dstall();
        d_mem_req  = 1'b1;
        d_mem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (load_pc !== 1'b0 || load_reg !== 4'b1000) begin
                n_err++;
                $display("[TB] FAIL dstall_ctl_%0d: pc=%b lr=%b want pc=0 lr=1000", i, load_pc, load_reg);
            end
            tick();
            n_cmp++;
            if (stage_valid !== 5'b01111) begin
                n_err++;
                $display("[TB] FAIL dstall_sv_%0d: got %b want 01111", i, stage_valid);
            end
        end
        n_cmp++;
        if (stall_count !== 4'd3) begin
            n_err++;
            $display("[TB] FAIL dstall_count: got %0d want 3", stall_count);
        end
        d_mem_resp = 1'b1;
        #1;
        n_cmp++;
        if (load_pc !== 1'b1 || load_reg !== 4'b1111) begin
            n_err++;
            $display("[TB] FAIL dstall_release_ctl: pc=%b lr=%b want pc=1 lr=1111", load_pc, load_reg);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b11111 || stall_count !== 4'd3) begin
            n_err++;
            $display("[TB] FAIL dstall_release: sv=%b stall=%0d want 11111/3", stage_valid, stall_count);
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        load_hazard = 1'b1;
        #1;
        n_cmp++;
        if (load_pc !== 1'b0 || load_reg !== 4'b1110) begin
            n_err++;
            $display("[TB] FAIL hazard_ctl: pc=%b lr=%b want pc=0 lr=1110", load_pc, load_reg);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b11011 || stall_count !== 4'd4) begin
            n_err++;
            $display("[TB] FAIL hazard_sv: sv=%b stall=%0d want 11011/4", stage_valid, stall_count);
        end
        load_hazard = 1'b0;
        i_mem_resp  = 1'b0;
        #1;
        n_cmp++;
        if (load_pc !== 1'b0 || load_reg !== 4'b1111) begin
            n_err++;
            $display("[TB] FAIL imiss_ctl: pc=%b lr=%b want pc=0 lr=1111", load_pc, load_reg);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b10101 || stall_count !== 4'd5) begin
            n_err++;
            $display("[TB] FAIL imiss_sv: sv=%b stall=%0d want 10101/5", stage_valid, stall_count);
        end
        refill("hazard");
    endtask

    task automatic test_branch();
        br_taken = 1'b1;
        #1;
        n_cmp++;
        if (redirect !== 1'b1 || load_pc !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL branch_ctl: rd=%b pc=%b want 1/1", redirect, load_pc);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b10001 || flush_count !== 4'd1 || stall_count !== 4'd5) begin
            n_err++;
            $display("[TB] FAIL branch_flush: sv=%b flush=%0d stall=%0d want 10001/1/5",
                     stage_valid, flush_count, stall_count);
        end
        refill("branch");
    endtask

    task automatic test_branch_dstall();
        br_taken   = 1'b1;
        d_mem_req  = 1'b1;
        d_mem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (redirect !== 1'b0 || load_pc !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL brds_hold_%0d: rd=%b pc=%b want 0/0", i, redirect, load_pc);
            end
            tick();
        end
        n_cmp++;
        if (stage_valid !== 5'b01111 || flush_count !== 4'd1 || stall_count !== 4'd7) begin
            n_err++;
            $display("[TB] FAIL brds_stalled: sv=%b flush=%0d stall=%0d want 01111/1/7",
                     stage_valid, flush_count, stall_count);
        end
        d_mem_resp = 1'b1;
        #1;
        n_cmp++;
        if (redirect !== 1'b1 || load_pc !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL brds_release_ctl: rd=%b pc=%b want 1/1", redirect, load_pc);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b10001 || flush_count !== 4'd2 || stall_count !== 4'd7) begin
            n_err++;
            $display("[TB] FAIL brds_flush: sv=%b flush=%0d stall=%0d want 10001/2/7",
                     stage_valid, flush_count, stall_count);
        end
        refill("brds");
    endtask

    task automatic test_simultaneous();
        load_hazard = 1'b1;
        br_taken    = 1'b1;
        #1;
        n_cmp++;
        if (redirect !== 1'b1 || load_pc !== 1'b1 || load_reg !== 4'b1110) begin
            n_err++;
            $display("[TB] FAIL haz_br_ctl: rd=%b pc=%b lr=%b want 1/1/1110", redirect, load_pc, load_reg);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b10001 || flush_count !== 4'd3 || stall_count !== 4'd8) begin
            n_err++;
            $display("[TB] FAIL haz_br_flush: sv=%b flush=%0d stall=%0d want 10001/3/8",
                     stage_valid, flush_count, stall_count);
        end
        refill("simul");
        d_mem_req   = 1'b1;
        d_mem_resp  = 1'b0;
        load_hazard = 1'b1;
        i_mem_resp  = 1'b0;
        #1;
        n_cmp++;
        if (load_reg !== 4'b1000 || load_pc !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL prio_ctl: lr=%b pc=%b want 1000/0", load_reg, load_pc);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b01111 || stall_count !== 4'd9) begin
            n_err++;
            $display("[TB] FAIL prio_state: sv=%b stall=%0d want 01111/9", stage_valid, stall_count);
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        i_mem_resp = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (stall_count !== 4'd15 || flush_count !== 4'd3) begin
            n_err++;
            $display("[TB] FAIL saturate: stall=%0d flush=%0d want 15/3", stall_count, flush_count);
        end
        cnt_clear = 1'b1;
        tick();
        n_cmp++;
        if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
            n_err++;
            $display("[TB] FAIL clear: stall=%0d flush=%0d want 0/0", stall_count, flush_count);
        end
        cnt_clear = 1'b0;
        tick();
        n_cmp++;
        if (stall_count !== 4'd1) begin
            n_err++;
            $display("[TB] FAIL count_after_clear: got %0d want 1", stall_count);
        end
        refill("sat");
    endtask

    task automatic test_reset_mid_stall();
        br_taken   = 1'b1;
        d_mem_req  = 1'b1;
        d_mem_resp = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({stage_valid, load_reg, load_pc, redirect} !== 11'b0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_comb: sv=%b lr=%b pc=%b rd=%b want all 0",
                     stage_valid, load_reg, load_pc, redirect);
        end
        tick();
        n_cmp++;
        if (stage_valid !== 5'b0 || stall_count !== 4'd0 || flush_count !== 4'd0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_state: sv=%b stall=%0d flush=%0d want 0/0/0",
                     stage_valid, stall_count, flush_count);
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (stage_valid !== 5'b00001 || redirect !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rst_release: sv=%b rd=%b want 00001/0", stage_valid, redirect);
        end
    endtask

    // Scenario sequence; each step starts from the state the previous one left.
    initial begin
        test_reset();
        test_fill();
        test_dstall();
        test_hazard();
        test_branch();
        test_branch_dstall();
        test_simultaneous();
        test_saturate();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
